bcd_up_counter: RTL

BCD_UP_COUNTER -- requirements
Module: bcd_up_counter

---
 rtl/bcd_up_counter_pkg.sv | 15 +
 rtl/bcd_to_ssd.sv | 24 ++
 rtl/bcd_up_counter.sv | 119 +++++++++++
 3 files changed

// File: rtl/bcd_up_counter_pkg.sv
// bcd_up_counter_pkg: FSM state encoding and seven-segment constants shared by the counter
package bcd_up_counter_pkg;
  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;
  localparam logic [7:0] SEG_0 = 8'h03;
  localparam logic [7:0] SEG_1 = 8'h9F;
  localparam logic [7:0] SEG_2 = 8'h25;
  localparam logic [7:0] SEG_3 = 8'h0D;
  localparam logic [7:0] SEG_4 = 8'h99;
  localparam logic [7:0] SEG_5 = 8'h49;
  localparam logic [7:0] SEG_6 = 8'h41;
  localparam logic [7:0] SEG_7 = 8'h1F;
  localparam logic [7:0] SEG_8 = 8'h01;
  localparam logic [7:0] SEG_9 = 8'h09;
  localparam logic [7:0] SEG_BLANK = 8'hFF;
endpackage

// File: rtl/bcd_to_ssd.sv
// bcd_to_ssd: BCD digit to active-low {a..g,dp} segment pattern, blank for non-decimal codes
module bcd_to_ssd
  import bcd_up_counter_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [7:0] seg
);
  // plain lookup, dp always off
  always_comb begin
    case (bcd)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end
endmodule

// File: rtl/bcd_up_counter.sv
// bcd_up_counter: two-digit BCD stopwatch with start/pause/clear button and multiplexed display
module bcd_up_counter
  import bcd_up_counter_pkg::*;
#(
  parameter int TICK_DIV = 50_000_000,
  parameter int SCAN_DIV = 65_536,
  parameter int LIMIT_TENS = 3,
  parameter int LIMIT_ONES = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_btn,
  output logic [7:0] D_ssd,
  output logic [3:0] ssd_ctl,
  output logic       done,
  output logic       running
);
  localparam int TW = $clog2(TICK_DIV);
  localparam int SW = $clog2(SCAN_DIV);
  localparam logic [3:0] LIM_T = 4'(LIMIT_TENS);
  localparam logic [3:0] LIM_O = 4'(LIMIT_ONES);
  localparam bit LIM_ZERO = (LIMIT_TENS == 0) && (LIMIT_ONES == 0);
  state_t state;
  logic btn_q, press, tick, slot, hit;
  logic [TW-1:0] tick_cnt;
  logic [SW-1:0] scan_cnt;
  logic [3:0] ones, tens, ones_inc, tens_inc, digit;
  logic [7:0] seg;
  assign press = start_btn & ~btn_q;
  assign tick = tick_cnt == TW'(TICK_DIV - 1);
  assign ones_inc = (ones == 4'd9) ? 4'd0 : ones + 4'd1;
  assign tens_inc = (ones != 4'd9) ? tens : (tens == 4'd9) ? 4'd0 : tens + 4'd1;
  // a zero limit would otherwise match the 99->00 rollover, so it never terminates
  assign hit = ({tens_inc, ones_inc} == {LIM_T, LIM_O}) && !LIM_ZERO;
  assign digit = slot ? tens : ones;
  // button edge register and free-running tick divider
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_q <= 1'b0;
      tick_cnt <= '0;
    end else begin
      btn_q <= start_btn;
      tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
    end
  end
  // scan divider toggling the displayed digit slot
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt <= '0;
      slot <= 1'b0;
    end else begin
      scan_cnt <= (scan_cnt == SW'(SCAN_DIV - 1)) ? '0 : scan_cnt + 1'b1;
      slot <= (scan_cnt == SW'(SCAN_DIV - 1)) ? ~slot : slot;
    end
  end
  // control FSM with the BCD count and registered status flags; a press outranks a tick
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ones <= 4'd0;
      tens <= 4'd0;
      done <= 1'b0;
      running <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          ones <= 4'd0;
          tens <= 4'd0;
          if (press) begin
            state <= RUN;
            running <= 1'b1;
          end
        end
        RUN: begin
          if (press) begin
            state <= PAUSE;
            running <= 1'b0;
          end else if (tick) begin
            ones <= ones_inc;
            tens <= tens_inc;
            if (hit) begin
              state <= DONE;
              done <= 1'b1;
              running <= 1'b0;
            end
          end
        end
        PAUSE: begin
          if (press) begin
            state <= RUN;
            running <= 1'b1;
          end
        end
        DONE: begin
          if (press) begin
            state <= IDLE;
            ones <= 4'd0;
            tens <= 4'd0;
            done <= 1'b0;
          end
        end
      endcase
    end
  end
  bcd_to_ssd u_seg (
    .bcd(digit),
    .seg(seg)
  );
  // registered display drive, one cycle behind slot and digit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      D_ssd <= 8'hFF;
      ssd_ctl <= 4'b1111;
    end else begin
      D_ssd <= seg;
      ssd_ctl <= slot ? 4'b1101 : 4'b1110;
    end
  end
endmodule
